spi_block_ctrl: RTL and testbench

Transaction controller that moves one full AES block (default 16 bytes) over the SPI link, full duplex, as a single chip-select frame.
- Accepts a start request with a 128-bit tx block.
- Frames the transfer with CS and serialises bytes MSB-first on MOSI.
- Assembles the bytes returned on MISO into a 128-bit rx block.
- Signals completion with a one-cycle done pulse.
- Sits between the AES core and the SPI pins, sequencing the byte-level master datapath.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_byte_shifter.sv | 44 ++++
 rtl/spi_block_ctrl.sv | 126 ++++++++++++
 tb/tb_spi_block_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI block controller: FSM states and default sizing.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam int BYTE_W          = 8;
  localparam int DEF_NUM_BYTES   = 16;
  localparam int DEF_GAP_CYCLES  = 2;

endpackage

// File: rtl/spi_byte_shifter.sv
// Byte-level SPI master datapath: parallel-load tx shifter, rx shifter and bit counter.
module spi_byte_shifter
  import spi_pkg::*;
(
  input  logic              sclk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] load_byte,
  input  logic              miso,
  output logic              mosi,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_done
);

  logic [BYTE_W-1:0] tx_sh;
  logic [BYTE_W-2:0] rx_sh;
  logic [2:0]        bit_cnt;

  // rx_byte includes the bit sampled on this edge, so it is the complete byte when byte_done is high.
  assign rx_byte   = {rx_sh, miso};
  assign mosi      = tx_sh[BYTE_W-1];
  assign byte_done = shift && (bit_cnt == 3'd7);

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else begin
      if (load) begin
        tx_sh   <= load_byte;
        bit_cnt <= '0;
      end else if (shift) begin
        tx_sh   <= {tx_sh[BYTE_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift) begin
        rx_sh <= rx_byte[BYTE_W-2:0];
      end
    end
  end

endmodule

// File: rtl/spi_block_ctrl.sv
// Moves one NUM_BYTES block over SPI as a single CS frame, full duplex, MSB first.
// Handshake: start is taken only in IDLE; busy covers the whole frame; done pulses once in FINISH.
module spi_block_ctrl
  import spi_pkg::*;
#(
  parameter int NUM_BYTES  = DEF_NUM_BYTES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                        sclk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_BYTES*BYTE_W-1:0] tx_block,
  output logic [NUM_BYTES*BYTE_W-1:0] rx_block,
  output logic                        busy,
  output logic                        done,
  output logic                        CS,
  output logic                        MOSI,
  input  logic                        MISO
);

  localparam int W   = NUM_BYTES * BYTE_W;
  localparam int BCW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(NUM_BYTES - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t              state, state_nxt;
  logic [W-1:0]        tx_reg, rx_acc, rx_acc_nxt;
  logic [BCW-1:0]      byte_cnt;
  logic [GCW-1:0]      gap_cnt;
  logic                accept, next_byte, gap_tick, last_byte;
  logic                sh_load, sh_shift, sh_mosi, byte_done;
  logic [BYTE_W-1:0]   rx_byte;

  spi_byte_shifter u_shifter (
    .sclk      (sclk),
    .reset     (reset),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_byte (tx_reg[W-1 -: BYTE_W]),
    .miso      (MISO),
    .mosi      (sh_mosi),
    .rx_byte   (rx_byte),
    .byte_done (byte_done)
  );

  assign sh_shift   = (state == SHIFT);
  assign last_byte  = byte_done && (byte_cnt == BYTE_LAST);
  assign rx_acc_nxt = (rx_acc << BYTE_W) | W'(rx_byte);

  assign MOSI = sh_shift & sh_mosi;
  assign CS   = (state == IDLE) || (state == FINISH);
  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sh_load   = 1'b0;
    next_byte = 1'b0;
    gap_tick  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          accept    = 1'b1;
        end
      end
      SETUP: begin
        state_nxt = SHIFT;
        sh_load   = 1'b1;
      end
      SHIFT: begin
        if (byte_done) begin
          if (last_byte) begin
            state_nxt = FINISH;
          end else if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
          end else begin
            next_byte = 1'b1;
            sh_load   = 1'b1;
          end
        end
      end
      GAP: begin
        gap_tick = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          state_nxt = SHIFT;
          next_byte = 1'b1;
          sh_load   = 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx_reg always holds the next byte to load at its top; it advances one byte per load.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      tx_reg   <= '0;
      rx_acc   <= '0;
      rx_block <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (accept) begin
        tx_reg   <= tx_block;
        rx_acc   <= '0;
        byte_cnt <= '0;
      end else begin
        if (sh_load)   tx_reg   <= tx_reg << BYTE_W;
        if (next_byte) byte_cnt <= byte_cnt + 1'b1;
        if (byte_done) rx_acc   <= rx_acc_nxt;
      end
      if (last_byte) rx_block <= rx_acc_nxt;
      gap_cnt <= (gap_tick && (gap_cnt != GAP_LAST)) ? gap_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_spi_block_ctrl.sv
// Directed bench for spi_block_ctrl: table of whole-frame vectors plus reset and short-frame sequences.
module tb_spi_block_ctrl;

  localparam int N  = 16;
  localparam int G  = 2;
  localparam int W  = N * 8;
  localparam int LAT = 1 + 8 * N + (N - 1) * G;

  localparam int N2 = 2;
  localparam int G2 = 0;
  localparam int W2 = N2 * 8;
  localparam int LAT2 = 1 + 8 * N2 + (N2 - 1) * G2;

  logic           sclk = 1'b0;
  logic           reset;
  logic           start, start2;
  logic [W-1:0]   tx_block, rx_block;
  logic [W2-1:0]  tx_block2, rx_block2;
  logic           busy, done, cs, mosi, miso;
  logic           busy2, done2, cs2, mosi2, miso2;
  int             mode;
  int             n_cmp = 0;
  int             n_fail = 0;
  logic [W-1:0]   last_rx;

  typedef struct {
    logic [W-1:0] tx;
    int           mode;
    logic [W-1:0] exp_rx;
    bit           poke;
  } vec_t;

  vec_t vecs[5];

  always #5 sclk = ~sclk;

  // mode 0: loopback, 1: MISO stuck high, 2: MISO stuck low
  assign miso = (mode == 0) ? mosi : (mode == 1);

  spi_block_ctrl #(.NUM_BYTES(N), .GAP_CYCLES(G)) dut (
    .sclk(sclk), .reset(reset), .start(start), .tx_block(tx_block),
    .rx_block(rx_block), .busy(busy), .done(done), .CS(cs), .MOSI(mosi), .MISO(miso)
  );

  spi_block_ctrl #(.NUM_BYTES(N2), .GAP_CYCLES(G2)) dut2 (
    .sclk(sclk), .reset(reset), .start(start2), .tx_block(tx_block2),
    .rx_block(rx_block2), .busy(busy2), .done(done2), .CS(cs2), .MOSI(mosi2), .MISO(miso2)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected MOSI after edge Ek: the bit of its slot during SHIFT, otherwise 0.
  function automatic logic exp_mosi(input logic [W-1:0] tx, input int w, input int n,
                                    input int g, input int k);
    int off, b, i;
    if (k < 1) return 1'b0;
    off = k - 1;
    b = off / (8 + g);
    i = off % (8 + g);
    if (b >= n || i >= 8) return 1'b0;
    return tx[w - 1 - (8 * b + i)];
  endfunction

  // Called at a negedge; the following posedge is E0.
  task automatic run_frame(input logic [W-1:0] tx, input logic [W-1:0] exp_rx, input bit poke);
    start = 1'b1;
    tx_block = tx;
    @(posedge sclk);
    #1;
    start = 1'b0;
    tx_block = ~tx;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge sclk);
      if (poke) start = (k == 19) || (k == LAT - 1);
      chk($sformatf("cs k=%0d", k),   W'(cs),   W'(k >= LAT));
      chk($sformatf("done k=%0d", k), W'(done), W'(k == LAT));
      chk($sformatf("busy k=%0d", k), W'(busy), W'(k <= LAT));
      chk($sformatf("mosi k=%0d", k), W'(mosi), W'(exp_mosi(tx, W, N, G, k)));
      if (k == 0 || k == 20 || k == LAT - 1)
        chk($sformatf("rx_hold k=%0d", k), rx_block, last_rx);
      if (k >= LAT)
        chk($sformatf("rx k=%0d", k), rx_block, exp_rx);
    end
    last_rx = exp_rx;
  endtask

  initial begin
    logic [W2-1:0] tx2, slave2;

    vecs[0] = '{tx: 128'h000102030405060708090A0B0C0D0E0F, mode: 0,
                exp_rx: 128'h000102030405060708090A0B0C0D0E0F, poke: 1'b0};
    vecs[1] = '{tx: 128'h0, mode: 1,
                exp_rx: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, poke: 1'b0};
    vecs[2] = '{tx: 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE, mode: 0,
                exp_rx: 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE, poke: 1'b1};
    vecs[3] = '{tx: 128'h80000000_00000000_00000000_00000001, mode: 0,
                exp_rx: 128'h80000000_00000000_00000000_00000001, poke: 1'b0};
    vecs[4] = '{tx: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, mode: 2,
                exp_rx: 128'h0, poke: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    tx_block = '0;
    tx_block2 = '0;
    miso2 = 1'b0;
    mode = 0;
    last_rx = '0;
    repeat (3) @(negedge sclk);
    chk("reset cs",   W'(cs),   W'(1'b1));
    chk("reset mosi", W'(mosi), W'(1'b0));
    chk("reset busy", W'(busy), W'(1'b0));
    chk("reset done", W'(done), W'(1'b0));
    chk("reset rx",   rx_block, '0);
    chk("reset cs2",  W'(cs2),  W'(1'b1));
    reset = 1'b0;
    @(negedge sclk);

    // vecs[3] immediately follows the poked frame, so its start lands on E161
    for (int v = 0; v < 5; v++) begin
      mode = vecs[v].mode;
      run_frame(vecs[v].tx, vecs[v].exp_rx, vecs[v].poke);
    end

    // Asynchronous reset in the middle of a frame.
    mode = 0;
    run_frame(vecs[2].tx, vecs[2].exp_rx, 1'b0);
    start = 1'b1;
    tx_block = vecs[0].tx;
    @(posedge sclk);
    #1 start = 1'b0;
    for (int k = 0; k <= 50; k++) @(negedge sclk);
    chk("pre-reset busy", W'(busy), W'(1'b1));
    reset = 1'b1;
    #1;
    chk("async cs",   W'(cs),   W'(1'b1));
    chk("async busy", W'(busy), W'(1'b0));
    chk("async done", W'(done), W'(1'b0));
    chk("async rx",   rx_block, '0);
    @(negedge sclk);
    reset = 1'b0;
    last_rx = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge sclk);
      chk($sformatf("post-reset done k=%0d", k), W'(done), W'(1'b0));
      chk($sformatf("post-reset cs k=%0d", k),   W'(cs),   W'(1'b1));
    end
    run_frame(vecs[0].tx, vecs[0].exp_rx, 1'b0);

    // Two-byte, no-gap frame against a slave returning 16'h3CC3.
    tx2 = 16'hA55A;
    slave2 = 16'h3CC3;
    start2 = 1'b1;
    tx_block2 = tx2;
    @(posedge sclk);
    #1;
    start2 = 1'b0;
    tx_block2 = 16'h0000;
    for (int k = 0; k <= LAT2 + 1; k++) begin
      @(negedge sclk);
      miso2 = (k >= 1 && k <= 16) ? slave2[16 - k] : 1'b0;
      chk($sformatf("cs2 k=%0d", k),   W'(cs2),   W'(k >= LAT2));
      chk($sformatf("done2 k=%0d", k), W'(done2), W'(k == LAT2));
      chk($sformatf("mosi2 k=%0d", k), W'(mosi2), W'(exp_mosi(W'(tx2), W2, N2, G2, k)));
      if (k >= LAT2) chk($sformatf("rx2 k=%0d", k), W'(rx_block2), W'(16'h3CC3));
    end
    chk("busy2 idle", W'(busy2), W'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
